// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: hit answers 1 cycle after en_i, miss refills the line word 0 first.
// Miss latency 2 + refill cycles; bus wait states (ack low) stall the refill, the core waits on data_ready_o.
module icache_dm #(
   parameter int INDEX_BITS  = 6,
   parameter int OFFSET_BITS = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] addr_i,
   input  logic        invalidate_i,
   output logic [31:0] data_o,
   output logic        data_ready_o,
   output logic        busy_o,
   output logic        mem_cyc_o,
   output logic        mem_stb_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_adr_o,
   input  logic [31:0] mem_dat_i,
   input  logic        mem_ack_i
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int WORDS = 1 << (INDEX_BITS + OFFSET_BITS);
   localparam int TAG_W = 32 - INDEX_BITS - OFFSET_BITS - 2;

   typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP, S_FLUSH} state_t;
   state_t state_q, state_d;

   logic [31:0]      data_mem [WORDS];
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [LINES-1:0] valid_q;

   logic [OFFSET_BITS-1:0] req_off, fill_off_q, fill_cnt_q;
   logic [INDEX_BITS-1:0]  req_idx, fill_idx_q, flush_cnt_q;
   logic [TAG_W-1:0]       req_tag, fill_tag_q;
   logic                   inv_pend_q;
   logic                   lookup, hit, last_ack;
   logic                   unused_addr_bits;

   assign req_off = addr_i[OFFSET_BITS+1:2];
   assign req_idx = addr_i[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
   assign req_tag = addr_i[31:32-TAG_W];
   assign unused_addr_bits = ^addr_i[1:0];

   // The cycle carrying data_ready_o never starts a lookup: the core re-presents en_i afterwards.
   assign lookup   = (state_q == S_IDLE) && en_i && !invalidate_i && !data_ready_o;
   assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign last_ack = (state_q == S_REFILL) && mem_ack_i && (fill_cnt_q == '1);

   assign mem_we_o  = 1'b0;
   assign mem_sel_o = 4'hF;
   assign busy_o    = (state_q != S_IDLE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (invalidate_i)        state_d = S_FLUSH;
            else if (lookup && !hit) state_d = S_REFILL;
         end
         S_REFILL: if (last_ack) state_d = S_RESP;
         S_RESP:   state_d = (inv_pend_q || invalidate_i) ? S_FLUSH : S_IDLE;
         S_FLUSH:  if (flush_cnt_q == '1) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q      <= '0;
         data_o       <= '0;
         data_ready_o <= 1'b0;
         mem_cyc_o    <= 1'b0;
         mem_stb_o    <= 1'b0;
         mem_adr_o    <= '0;
         fill_idx_q   <= '0;
         fill_off_q   <= '0;
         fill_tag_q   <= '0;
         fill_cnt_q   <= '0;
         flush_cnt_q  <= '0;
         inv_pend_q   <= 1'b0;
      end else begin
         data_ready_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (invalidate_i) begin
                  flush_cnt_q <= '0;
               end else if (lookup) begin
                  fill_idx_q <= req_idx;
                  fill_off_q <= req_off;
                  fill_tag_q <= req_tag;
                  if (hit) begin
                     data_ready_o <= 1'b1;
                     data_o       <= data_mem[{req_idx, req_off}];
                  end else begin
                     mem_cyc_o  <= 1'b1;
                     mem_stb_o  <= 1'b1;
                     mem_adr_o  <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}, 2'b00};
                     fill_cnt_q <= '0;
                  end
               end
            end
            S_REFILL: begin
               if (invalidate_i) inv_pend_q <= 1'b1;
               if (mem_ack_i) begin
                  fill_cnt_q <= fill_cnt_q + 1'b1;
                  mem_adr_o  <= mem_adr_o + 32'd4;
                  if (last_ack) begin
                     mem_cyc_o           <= 1'b0;
                     mem_stb_o           <= 1'b0;
                     valid_q[fill_idx_q] <= 1'b1;
                  end
               end
            end
            S_RESP: begin
               data_ready_o <= 1'b1;
               data_o       <= data_mem[{fill_idx_q, fill_off_q}];
               inv_pend_q   <= 1'b0;
               flush_cnt_q  <= '0;
            end
            S_FLUSH: begin
               valid_q[flush_cnt_q] <= 1'b0;
               flush_cnt_q          <= flush_cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Storage arrays carry no reset; valid_q alone decides whether a line is usable.
   always_ff @(posedge clk_i) begin
      if (state_q == S_REFILL && mem_ack_i) begin
         data_mem[{fill_idx_q, fill_cnt_q}] <= mem_dat_i;
         if (fill_cnt_q == '1) tag_mem[fill_idx_q] <= fill_tag_q;
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed vector table, hand-written flush/reset sequences, and a randomized run
// checked against a line-level cache model. Backing memory returns each word's own address.
module tb_icache_dm;
   logic        clk_i, rst_i, en_i, invalidate_i, mem_ack_i;
   logic [31:0] addr_i, mem_dat_i, data_o, mem_adr_o;
   logic        data_ready_o, busy_o, mem_cyc_o, mem_stb_o, mem_we_o;
   logic [3:0]  mem_sel_o;

   icache_dm dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .addr_i(addr_i),
      .invalidate_i(invalidate_i), .data_o(data_o), .data_ready_o(data_ready_o),
      .busy_o(busy_o), .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o),
      .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_adr_o(mem_adr_o),
      .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_chk = 0, n_pass = 0;
   int wait_states = 0, acks_given = 0, stb_cycles = 0, hold_err = 0;
   bit spur_ack = 0;
   logic [31:0] bus_log[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Memory slave: acks after wait_states idle cycles per word, data = word address.
   initial begin : responder
      int wcnt;
      logic [31:0] hold_adr;
      wcnt = 0; hold_adr = '0;
      mem_ack_i = 1'b0; mem_dat_i = 32'hDEADBEEF;
      forever begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         mem_dat_i = 32'hDEADBEEF;
         if (rst_i && mem_cyc_o && mem_stb_o) begin
            stb_cycles++;
            if (wcnt == 0) hold_adr = mem_adr_o;
            else if (mem_adr_o !== hold_adr) hold_err++;
            if (wcnt >= wait_states) begin
               mem_ack_i = 1'b1;
               mem_dat_i = mem_adr_o;
               bus_log.push_back(mem_adr_o);
               acks_given++;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
         if (spur_ack) mem_ack_i = 1'b1;
      end
   end

   // Presents a request one negedge after the call; lat = cycles from en_i sampled to data_ready_o, -1 on timeout.
   task automatic fetch(input logic [31:0] a, input int inv_at, output logic [31:0] d, output int lat);
      d = '0; lat = -1;
      @(negedge clk_i);
      en_i = 1'b1; addr_i = a; invalidate_i = (inv_at == 0);
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk_i);
         invalidate_i = (c == inv_at);
         if (data_ready_o) begin
            d = data_o; lat = c;
            break;
         end
      end
      en_i = 1'b0; invalidate_i = 1'b0;
   endtask

   task automatic fx(input string nm, input logic [31:0] a, input int w, input int inv_at, input int exp_lat);
      logic [31:0] d;
      int lat, n0;
      wait_states = w; n0 = acks_given;
      fetch(a, inv_at, d, lat);
      check({nm, "_data"}, d, a & ~32'h3);
      check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
      check({nm, "_acks"}, 32'(acks_given - n0), (exp_lat == 1) ? 32'd0 : 32'd4);
   endtask

   task automatic count_busy(input string nm);
      int cnt;
      cnt = 0;
      while (busy_o && cnt < 200) begin
         cnt++;
         @(negedge clk_i);
      end
      check(nm, 32'(cnt), 32'd64);
   endtask

   typedef struct {
      logic [31:0] addr;
      int          waits;
      bit          miss;
      int          lat;
      logic [31:0] data;
   } vec_t;
   localparam int NV = 8;
   vec_t vecs[NV];

   bit          mv[64];
   logic [21:0] mt[64];

   initial begin : main
      logic [31:0] d, a;
      int lat, s0, n0, tg, ix, w;
      bit exp_hit;

      vecs[0] = '{32'h0000_0014, 0, 1'b1,  6, 32'h0000_0014};
      vecs[1] = '{32'h0000_001C, 0, 1'b0,  1, 32'h0000_001C};
      vecs[2] = '{32'h0000_0418, 0, 1'b1,  6, 32'h0000_0418};
      vecs[3] = '{32'h0000_0010, 0, 1'b1,  6, 32'h0000_0010};
      vecs[4] = '{32'h0000_0100, 3, 1'b1, 18, 32'h0000_0100};
      vecs[5] = '{32'h0000_010C, 0, 1'b0,  1, 32'h0000_010C};
      vecs[6] = '{32'h0000_041B, 1, 1'b1, 10, 32'h0000_0418};
      vecs[7] = '{32'h0000_041E, 0, 1'b0,  1, 32'h0000_041C};

      en_i = 1'b0; invalidate_i = 1'b0; addr_i = '0;
      rst_i = 1'b1;
      #2 rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_ready", {31'b0, data_ready_o}, 32'd0);
      check("rst_busy",  {31'b0, busy_o}, 32'd0);
      check("rst_cyc",   {31'b0, mem_cyc_o}, 32'd0);
      check("rst_stb",   {31'b0, mem_stb_o}, 32'd0);
      check("rst_adr",   mem_adr_o, 32'd0);
      check("rst_data",  data_o, 32'd0);
      check("rst_we",    {31'b0, mem_we_o}, 32'd0);
      check("rst_sel",   {28'b0, mem_sel_o}, 32'hF);
      rst_i = 1'b1;

      for (int i = 0; i < NV; i++) begin
         wait_states = vecs[i].waits;
         bus_log.delete();
         s0 = stb_cycles;
         fetch(vecs[i].addr, -1, d, lat);
         check($sformatf("vec%0d_data", i), d, vecs[i].data);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_stb_cycles", i), 32'(stb_cycles - s0),
               vecs[i].miss ? 32'(4 * (vecs[i].waits + 1)) : 32'd0);
         check($sformatf("vec%0d_reads", i), 32'(bus_log.size()), vecs[i].miss ? 32'd4 : 32'd0);
         if (vecs[i].miss && bus_log.size() == 4)
            for (int k = 0; k < 4; k++)
               check($sformatf("vec%0d_rd%0d_adr", i, k), bus_log[k],
                     (vecs[i].addr & ~32'hF) + 32'(4 * k));
      end
      check("adr_hold_during_wait", 32'(hold_err), 32'd0);

      // Invalidate in IDLE, then en_i raised together with invalidate_i on a cached line.
      fx("pre_inv_fill", 32'h1C, 0, -1, 6);
      fx("pre_inv_hit",  32'h1C, 0, -1, 1);
      @(negedge clk_i); invalidate_i = 1'b1;
      @(negedge clk_i); invalidate_i = 1'b0;
      count_busy("idle_flush_len");
      fx("post_inv_miss", 32'h1C, 0, -1, 6);
      fx("en_during_flush", 32'h1C, 0, 0, 71);

      // Invalidate while refilling: fetch finishes, then a full flush.
      fx("inv_refill", 32'h200, 1, 3, 10);
      count_busy("refill_flush_len");
      fx("inv_refill_after", 32'h200, 0, -1, 6);

      // Reset after two acks of a refill.
      wait_states = 0;
      @(negedge clk_i);
      en_i = 1'b1; addr_i = 32'h14; n0 = acks_given;
      for (int c = 0; c < 50 && acks_given < n0 + 2; c++) @(negedge clk_i);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      #1;
      check("midrst_cyc",  {31'b0, mem_cyc_o}, 32'd0);
      check("midrst_stb",  {31'b0, mem_stb_o}, 32'd0);
      check("midrst_busy", {31'b0, busy_o}, 32'd0);
      en_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i); rst_i = 1'b1;
      bus_log.delete();
      fx("midrst_refetch", 32'h14, 0, -1, 6);
      check("midrst_rd0_adr", (bus_log.size() > 0) ? bus_log[0] : 32'hFFFF_FFFF, 32'h10);
      fx("midrst_other_word", 32'h1C, 0, -1, 1);

      // Acks with no bus cycle open must be ignored.
      @(negedge clk_i); spur_ack = 1'b1;
      repeat (3) @(negedge clk_i);
      check("spur_cyc", {31'b0, mem_cyc_o}, 32'd0);
      spur_ack = 1'b0;
      repeat (2) @(negedge clk_i);
      fx("spur_hit", 32'h18, 0, -1, 1);

      for (int i = 0; i < 64; i++) begin mv[i] = 1'b0; mt[i] = '0; end
      mv[1] = 1'b1; mt[1] = 22'd0;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk_i); invalidate_i = 1'b1;
            @(negedge clk_i); invalidate_i = 1'b0;
            count_busy($sformatf("rnd%0d_flush", it));
            for (int i = 0; i < 64; i++) mv[i] = 1'b0;
         end
         tg = $urandom_range(0, 3);
         ix = $urandom_range(0, 7);
         w  = $urandom_range(0, 2);
         a  = 32'((tg << 10) | (ix << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
         exp_hit = mv[ix] && (mt[ix] == 22'(tg));
         fx($sformatf("rnd%0d", it), a, w, -1, exp_hit ? 1 : 2 + 4 * (w + 1));
         if (!exp_hit) begin mv[ix] = 1'b1; mt[ix] = 22'(tg); end
      end
      check("adr_hold_final", 32'(hold_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
